// File: rtl/pc_unit.sv
// pc_unit: 8-bit program counter with priority load/increment and a gated bus driver.
// Optional 4-entry return stack (call/return support) compiled in with `define PC_STACK_EN.
// Reset is synchronous and active-high; control inputs are sampled on the rising edge.
module pc_unit (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_bus,
  input  logic       i_ctrlLoadPC,
  input  logic       i_ctrlIncrPC,
  input  logic       i_ctrlPCNOe,
`ifdef PC_STACK_EN
  input  logic       i_ctrlPush,
  input  logic       i_ctrlPop,
  output logic       o_stackErr,
  output logic [2:0] o_stackDepth,
`endif
  output logic [7:0] o_bus,
  output logic       o_busEn,
  output logic [7:0] o_pc
);

  logic [7:0] r_pc;
  logic [7:0] pc_base;
  logic [7:0] pc_next;

  // Basic next-PC selection: load beats increment, otherwise hold (increment wraps mod 256)
  always_comb begin
    pc_base = r_pc;
    if (i_ctrlLoadPC)
      pc_base = i_bus;
    else if (i_ctrlIncrPC)
      pc_base = r_pc + 8'd1;
  end

`ifdef PC_STACK_EN
  logic [7:0] stack_mem [4];
  logic [2:0] depth;
  logic       stack_err;
  logic       stack_empty;
  logic       stack_full;
  logic       pop_ok;
  logic       pop_err;
  logic       push_ok;
  logic       push_err;
  logic [1:0] top_idx;
  logic [1:0] push_idx;
  logic [7:0] push_value;

  // Decode stack requests; a pop always wins over a simultaneous push
  always_comb begin
    stack_empty = (depth == 3'd0);
    stack_full  = (depth == 3'd4);
    pop_ok      = i_ctrlPop && !stack_empty;
    pop_err     = i_ctrlPop && stack_empty;
    push_ok     = i_ctrlPush && !i_ctrlPop && !stack_full;
    push_err    = i_ctrlPush && !i_ctrlPop && stack_full;
    top_idx     = depth[1:0] - 2'd1;
    push_idx    = depth[1:0];
    push_value  = i_ctrlLoadPC ? (r_pc + {7'd0, i_ctrlIncrPC}) : r_pc;
  end

  // Next PC with stack: valid pop overrides everything, an empty pop freezes the PC
  always_comb begin
    pc_next = pc_base;
    if (pop_ok)
      pc_next = stack_mem[top_idx];
    else if (pop_err)
      pc_next = r_pc;
  end

  // State update for PC, stack entries, depth and the sticky error flag
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc      <= 8'h00;
      depth     <= 3'd0;
      stack_err <= 1'b0;
      for (int i = 0; i < 4; i++)
        stack_mem[i] <= 8'h00;
    end else begin
      r_pc <= pc_next;
      if (push_ok) begin
        stack_mem[push_idx] <= push_value;
        depth               <= depth + 3'd1;
      end else if (pop_ok) begin
        depth <= depth - 3'd1;
      end
      if (pop_err || push_err)
        stack_err <= 1'b1;
    end
  end

  assign o_stackErr   = stack_err;
  assign o_stackDepth = depth;
`else
  assign pc_next = pc_base;

  // PC register update
  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_pc <= 8'h00;
    else
      r_pc <= pc_next;
  end
`endif

  assign o_pc    = r_pc;
  assign o_busEn = ~i_ctrlPCNOe;
  assign o_bus   = i_ctrlPCNOe ? 8'h00 : r_pc;

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have ports: i_clk  in  1  system clock; all state updates on posedge.
REQ-002 SHALL have ports: i_reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: i_bus  in  8  data bus value (jump target).
REQ-004 SHALL have ports: i_ctrlLoadPC  in  1  load PC from i_bus.
REQ-005 SHALL have ports: i_ctrlIncrPC  in  1  increment PC.
REQ-006 SHALL have ports: i_ctrlPCNOe  in  1  active-low bus output enable.
REQ-007 SHALL have ports: o_bus  out  8  PC value driven to the bus; 8'h00 when not enabled.
REQ-008 SHALL have ports: o_busEn  out  1  high when o_bus is valid, i.e. the inverse of i_ctrlPCNOe.
REQ-009 SHALL have ports: o_pc  out  8  current PC, continuously driven to the RAM address mux.
REQ-010 SHALL have ports, only with PC_STACK_EN: i_ctrlPush  in  1  push return address; i_ctrlPop  in  1  pop into PC; o_stackErr  out  1  sticky overflow/underflow flag; o_stackDepth  out  3  entries held (0-4).

Function
REQ-011 SHALL hold an 8-bit register r_pc; o_pc = r_pc at all times.
REQ-012 SHALL sample control inputs on posedge i_clk; control changes on negedge upstream, so inputs are stable half a cycle before sampling.
REQ-013 SHALL update r_pc by priority: pop (if enabled) > load > increment > hold.
REQ-014 SHALL set r_pc <= i_bus on load, visible on o_pc one cycle later.
REQ-015 SHALL set r_pc <= r_pc + 1 modulo 256 on increment; 8'hFF wraps to 8'h00 with no flag.
REQ-016 SHALL treat load and increment in the same cycle as load only; the increment is discarded.
REQ-017 SHALL drive o_bus = r_pc combinationally while i_ctrlPCNOe = 0, and 8'h00 otherwise.
REQ-018 SHALL reflect the pre-update r_pc on o_bus in the cycle a load or increment is sampled, with no bypass.

Reset
REQ-019 SHALL on posedge with i_reset = 1 set r_pc = 8'h00, and, if PC_STACK_EN, clear stack depth to 0, clear o_stackErr to 0, and zero all stack entries.
REQ-020 SHALL give i_reset priority over every control input, including a reset mid-push or mid-pop; that operation is discarded.
REQ-021 SHALL output after reset o_pc = 8'h00, o_bus = 8'h00 unless i_ctrlPCNOe = 0, and o_stackDepth = 0.

Configuration
REQ-022 SHALL compile in, when macro PC_STACK_EN is defined, a 4-entry LIFO return stack with the ports of REQ-010.
REQ-023 SHALL on push with load (call) write r_pc + i_ctrlIncrPC to the top, increment depth, and load r_pc from i_bus, all in one cycle.
REQ-024 SHALL on push without load write r_pc to the top and increment depth; r_pc follows REQ-013.
REQ-025 SHALL on pop with depth > 0 set r_pc <= top entry and decrement depth, overriding load and increment.
REQ-026 SHALL on push at depth 4 (full) drop the entry, leave depth at 4, and set o_stackErr; r_pc still loads or increments.
REQ-027 SHALL on pop at depth 0 (empty) leave r_pc unchanged, set o_stackErr, and ignore load and increment that cycle.
REQ-028 SHALL treat push and pop asserted together as pop only when depth > 0, and as error with no change when depth = 0.
REQ-029 SHALL keep o_stackErr set until reset.
REQ-030 SHALL, when PC_STACK_EN is undefined, contain no stack logic or ports; behaviour is REQ-011 to REQ-021 only.

Verification
REQ-031 SHALL cover reset: reset, then 3 increments -> o_pc = 8'h03; assert reset with increment -> o_pc = 8'h00.
REQ-032 SHALL cover wrap: load 8'hFE, then 2 increments -> o_pc = 8'h00 with no error.
REQ-033 SHALL cover priority: load 8'h40 with increment in the same cycle -> o_pc = 8'h40, not 8'h41.
REQ-034 SHALL cover bus drive: r_pc = 8'h12 with i_ctrlPCNOe = 0 -> o_bus = 8'h12 and o_busEn = 1; with i_ctrlPCNOe = 1 -> o_bus = 8'h00.
REQ-035 SHALL cover, with PC_STACK_EN, call and return: PC = 8'h10, call to 8'h80 with increment -> o_pc = 8'h80 and depth = 1; pop -> o_pc = 8'h11 and depth = 0.
REQ-036 SHALL cover, with PC_STACK_EN, limits: 5 pushes -> depth = 4 and o_stackErr = 1; after reset, pop on empty -> o_pc unchanged and o_stackErr = 1.
